nibble_scatter_packer: RTL and testbench

NIBBLE_SCATTER_PACKER -- requirements
Module: nibble_scatter_packer

---
 rtl/nibble_scatter_packer.sv | 93 +++++++++
 tb/tb_nibble_scatter_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_scatter_packer.sv
// Scatter-write frame buffer: random-access word writes fill N slots, then the
// complete frame is presented on dout until the consumer takes it.
module nibble_scatter_packer #(
    parameter int W  = 4,
    parameter int N  = 256,
    parameter int SW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SW-1:0]   in_sel,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  dout,
    output logic [SW:0]     fill_count
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);
    localparam logic [SW:0] CNT_FULL = (SW+1)'(N);

    state_t           state_q, state_d;
    logic [N*W-1:0]   buf_q, buf_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [SW:0]      cnt_q, cnt_d;
    logic             wr;

    assign in_ready   = (state_q == FILL) && !clear;
    assign wr         = in_valid && in_ready;
    assign out_valid  = (state_q == FULL);
    assign dout       = buf_q;
    assign fill_count = cnt_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = FILL;
            buf_d   = '0;
            mask_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (wr) begin
                        buf_d[in_sel*W +: W] = in_data;
                        mask_d[in_sel]       = 1'b1;
                        if (!mask_q[in_sel]) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        if (cnt_d == CNT_FULL) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    // Frame handed off: start the next one from an empty buffer
                    if (out_ready) begin
                        state_d = FILL;
                        buf_d   = '0;
                        mask_d  = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            buf_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nibble_scatter_packer.sv
// Directed self-checking bench for nibble_scatter_packer.
module tb_nibble_scatter_packer;

    localparam int W  = 4;
    localparam int N  = 256;
    localparam int SW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [SW-1:0]   in_sel;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [N*W-1:0]  dout;
    logic [SW:0]     fill_count;

    int compared = 0;
    int mism     = 0;
    int consumed = 0;

    logic [N*W-1:0]  refv;
    logic [W-1:0]    refa [N];
    int              perm [N];
    logic [W-1:0]    d;
    logic [W-1:0]    muxo;
    logic [N*W-1:0]  dsnap;

    always #5 clk = ~clk;

    nibble_scatter_packer #(.W(W), .N(N), .SW(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .fill_count (fill_count)
    );

    // Frames the bench sees taken by the consumer (reset overrides a handshake)
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready)
            consumed++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [N*W-1:0] obs,
                        input logic [N*W-1:0] exp);
        int bad;
        compared++;
        assert (obs === exp) else begin
            mism++;
            bad = 0;
            for (int i = N - 1; i >= 0; i--)
                if (obs[i*W +: W] !== exp[i*W +: W]) bad = i;
            $error("FAIL %s slot %0d observed=%0h expected=%0h", tag, bad,
                   obs[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    task automatic wr(input int sel, input logic [W-1:0] data);
        in_valid = 1'b1;
        in_sel   = SW'(sel);
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_sel = '0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fill", 64'(fill_count), 64'd0);
        chkw("rst_dout", dout, '0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Sequential fill, data = slot[3:0]
        refv = '0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_sel   = SW'(i);
            in_data  = W'(i);
            refv[i*W +: W] = W'(i);
            #1;
            chk("seq_in_ready", 64'(in_ready), 64'd1);
            step();
            chk("seq_fill", 64'(fill_count), 64'(i + 1));
            chk("seq_out_valid", 64'(out_valid), (i == N - 1) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;
        chkw("seq_dout", dout, refv);

        // Hold in FULL with writes attempted; nothing may change
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_sel   = SW'($urandom_range(N - 1, 0));
            in_data  = W'($urandom_range(15, 0));
            #1;
            chk("full_in_ready", 64'(in_ready), 64'd0);
            step();
            chkw("full_dout_hold", dout, refv);
            chk("full_out_valid", 64'(out_valid), 64'd1);
            chk("full_fill_hold", 64'(fill_count), 64'd256);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_out_valid", 64'(out_valid), 64'd0);
        chkw("hs_dout", dout, '0);
        chk("hs_fill", 64'(fill_count), 64'd0);
        chk("hs_in_ready", 64'(in_ready), 64'd1);
        chk("hs_consumed", 64'(consumed), 64'd1);

        // Overwrite same slot
        wr(7, 4'hA);
        wr(7, 4'h5);
        chk("ow_fill", 64'(fill_count), 64'd1);
        refv = '0;
        refv[31:28] = 4'h5;
        chkw("ow_dout", dout, refv);

        // Clear after 100 writes, colliding with a write to slot 200
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr0_fill", 64'(fill_count), 64'd0);
        for (int i = 0; i < 100; i++)
            wr(i * 2, W'($urandom_range(15, 1)));
        chk("c100_fill", 64'(fill_count), 64'd100);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 8'd200;
        in_data  = 4'hF;
        #1;
        chk("clr_in_ready", 64'(in_ready), 64'd0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_fill", 64'(fill_count), 64'd0);
        chkw("clr_dout", dout, '0);
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        wr(200, 4'h3);
        chk("clr_slot200_new", 64'(fill_count), 64'd1);

        // Random permutation fill
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        refv = '0;
        for (int i = 0; i < N; i++) begin
            d = W'($urandom_range(15, 0));
            refa[perm[i]] = d;
            refv[perm[i]*W +: W] = d;
            wr(perm[i], d);
        end
        chk("perm_out_valid", 64'(out_valid), 64'd1);
        chk("perm_fill", 64'(fill_count), 64'd256);
        chkw("perm_dout", dout, refv);
        dsnap = dout;
        for (int s = 0; s < N; s++) begin
            muxo = dsnap[s*W +: W];
            chk("perm_mux", 64'(muxo), 64'(refa[s]));
        end

        // Reset in FULL overrides a pending handshake
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        chk("rfull_out_valid", 64'(out_valid), 64'd0);
        chk("rfull_fill", 64'(fill_count), 64'd0);
        chkw("rfull_dout", dout, '0);
        chk("rfull_in_ready", 64'(in_ready), 64'd1);
        chk("rfull_consumed", 64'(consumed), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
